// File: rtl/chroma_upsample_stream.sv
// Chroma upsampler: accepts one subsampled block per handshake, rebuilds a full 8x8 block
// by sample replication (4:4:4 / 4:2:2 / 4:2:0) and streams it out one row per cycle.
module chroma_upsample_stream #(
   parameter int DW = 8,
   parameter int CH = 3,
   localparam int CW = $clog2(CH + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            valid_in,
   output logic                            ready_in,
   input  logic [CW-1:0]                   ch_in,
   input  logic [1:0]                      mode_in,
   input  logic signed [7:0][7:0][DW-1:0]  block_in,
   output logic                            valid_out,
   input  logic                            ready_out,
   output logic signed [7:0][DW-1:0]       row_out,
   output logic [2:0]                      row_idx_out,
   output logic [CW-1:0]                   ch_out,
   output logic                            last_out,
   output logic                            err_out
);

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [CW-1:0] CH_LIMIT = CW'(CH);

   state_t                  state;
   state_t                  state_next;
   logic [7:0][7:0][DW-1:0] buffer;
   logic [CW-1:0]           ch_q;
   logic [1:0]              mode_q;
   logic [2:0]              r;
   logic                    err_q;
   logic                    accept;
   logic                    illegal;
   logic                    take;

   // An illegal block still completes its handshake but never enters the buffer.
   assign illegal  = (ch_in >= CH_LIMIT) || (mode_in == 2'b11 && ch_in != '0);
   assign ready_in = (state == IDLE) || (state == STREAM && r == 3'd7 && ready_out);
   assign accept   = valid_in && ready_in;
   assign take     = accept && !illegal;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (take) state_next = STREAM;
         STREAM:  if (ready_out && r == 3'd7) state_next = take ? STREAM : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         buffer <= '0;
         ch_q   <= '0;
         mode_q <= 2'b00;
         r      <= 3'd0;
         err_q  <= 1'b0;
      end else begin
         state <= state_next;
         err_q <= accept && illegal;
         if (take) begin
            buffer <= block_in;
            ch_q   <= ch_in;
            mode_q <= (ch_in == '0) ? 2'b00 : mode_in;
            r      <= 3'd0;
         end else if (state == STREAM && ready_out) begin
            r <= r + 3'd1;
         end
      end
   end

   // Replication only: every output sample is a bit-exact copy of one buffered sample.
   always_comb begin
      valid_out   = (state == STREAM);
      row_out     = '0;
      row_idx_out = 3'd0;
      ch_out      = '0;
      last_out    = 1'b0;
      if (state == STREAM) begin
         row_idx_out = r;
         ch_out      = ch_q;
         last_out    = (r == 3'd7);
         for (int c = 0; c < 8; c++) begin
            case (mode_q)
               2'b01:   row_out[c] = buffer[r][c >> 1];
               2'b10:   row_out[c] = buffer[r >> 1][c >> 1];
               default: row_out[c] = buffer[r][c];
            endcase
         end
      end
   end

   assign err_out = err_q;

endmodule

// File: tb/tb_chroma_upsample_stream.sv
// Scoreboard bench for chroma_upsample_stream: expected rows are queued when a block is
// accepted and popped as the DUT hands rows downstream.
module tb_chroma_upsample_stream;

   typedef logic [7:0][7:0][7:0] blk_t;
   typedef logic [7:0][7:0]      row_t;
   typedef struct {
      row_t       row;
      logic [2:0] idx;
      logic [1:0] ch;
      logic       last;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               valid_in = 1'b0;
   logic               ready_in;
   logic [1:0]         ch_in = 2'd0;
   logic [1:0]         mode_in = 2'd0;
   logic signed [7:0][7:0][7:0] block_in = '0;
   logic               valid_out;
   logic               ready_out = 1'b0;
   logic signed [7:0][7:0] row_out;
   logic [2:0]         row_idx_out;
   logic [1:0]         ch_out;
   logic               last_out;
   logic               err_out;

   int   total = 0;
   int   bad = 0;
   exp_t sbq[$];

   chroma_upsample_stream #(.DW(8), .CH(3)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .ch_in(ch_in),
      .mode_in(mode_in), .block_in(block_in), .valid_out(valid_out), .ready_out(ready_out),
      .row_out(row_out), .row_idx_out(row_idx_out), .ch_out(ch_out), .last_out(last_out),
      .err_out(err_out)
   );

   always #5 clk = ~clk;

   function automatic blk_t make_blk(int kind);
      blk_t b;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            case (kind)
               0:       b[i][j] = (i < 4 && j < 4) ? 8'(16 * i + j) : 8'hEE;
               1:       b[i][j] = (j < 4) ? 8'(-(8 * i + j)) : 8'h5A;
               2:       b[i][j] = 8'(8 * i + j);
               default: b[i][j] = 8'($urandom);
            endcase
      return b;
   endfunction

   // Reference replication: luma is always passthrough, otherwise per-mode mapping.
   function automatic row_t model_row(blk_t blk, logic [1:0] ch, logic [1:0] mode, int r);
      row_t row;
      for (int c = 0; c < 8; c++)
         if (ch == 2'd0 || mode == 2'b00) row[c] = blk[r][c];
         else if (mode == 2'b01)          row[c] = blk[r][c / 2];
         else                             row[c] = blk[r / 2][c / 2];
      return row;
   endfunction

   task automatic push_block(input blk_t blk, input logic [1:0] ch, input logic [1:0] mode);
      exp_t e;
      for (int r = 0; r < 8; r++) begin
         e.row  = model_row(blk, ch, mode, r);
         e.idx  = 3'(r);
         e.ch   = ch;
         e.last = (r == 7);
         sbq.push_back(e);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      total++;
      if ({valid_out, row_out, row_idx_out, ch_out, last_out, err_out} !== '0) begin
         bad++;
         $display("FAIL reset_held got valid=%0b row=%h idx=%0d ch=%0d last=%0b err=%0b want all 0",
                  valid_out, row_out, row_idx_out, ch_out, last_out, err_out);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (ready_in !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready_in got=%0b want=1", ready_in);
      end
      total++;
      if ({valid_out, row_out, row_idx_out, ch_out, last_out, err_out} !== '0) begin
         bad++;
         $display("FAIL reset_released got valid=%0b row=%h idx=%0d ch=%0d last=%0b err=%0b want all 0",
                  valid_out, row_out, row_idx_out, ch_out, last_out, err_out);
      end
   endtask

   task automatic test_modes();
      blk_t       blk;
      logic [1:0] ch;
      logic [1:0] mode;
      exp_t       e;
      row_t       spot;
      bit         have;
      int         rows;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin ch = 2'd1; mode = 2'b10; end
            1:       begin ch = 2'd2; mode = 2'b01; end
            default: begin ch = 2'd0; mode = 2'b10; end
         endcase
         blk = make_blk(k);
         @(negedge clk);
         valid_in = 1'b1; ch_in = ch; mode_in = mode; block_in = blk; ready_out = 1'b1;
         #1;
         total++;
         if (ready_in !== 1'b1) begin
            bad++;
            $display("FAIL modes_ready_in case=%0d got=%0b want=1", k, ready_in);
         end
         push_block(blk, ch, mode);
         @(negedge clk);
         valid_in = 1'b0;
         rows = 0;
         for (int cyc = 1; cyc <= 10; cyc++) begin
            #1;
            total++;
            if (err_out !== 1'b0) begin
               bad++;
               $display("FAIL modes_err case=%0d cyc=%0d got=%0b want=0", k, cyc, err_out);
            end
            if (valid_out) begin
               rows++;
               if (sbq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL modes_extra_row case=%0d cyc=%0d got idx=%0d want no row", k, cyc, row_idx_out);
               end else begin
                  e = sbq.pop_front();
                  total++;
                  if ({row_out, row_idx_out, ch_out, last_out} !== {e.row, e.idx, e.ch, e.last}) begin
                     bad++;
                     $display("FAIL modes_row case=%0d got row=%h idx=%0d ch=%0d last=%0b want row=%h idx=%0d ch=%0d last=%0b",
                              k, row_out, row_idx_out, ch_out, last_out, e.row, e.idx, e.ch, e.last);
                  end
                  total++;
                  if (cyc !== int'(e.idx) + 1) begin
                     bad++;
                     $display("FAIL modes_latency case=%0d row=%0d got cycle=%0d want cycle=%0d", k, e.idx, cyc, int'(e.idx) + 1);
                  end
                  have = 1'b0;
                  for (int c = 0; c < 8; c++) begin
                     if (k == 0 && e.idx <= 3'd1) begin have = 1'b1; spot[c] = 8'(c / 2);         end
                     if (k == 0 && e.idx == 3'd6) begin have = 1'b1; spot[c] = 8'(48 + c / 2);    end
                     if (k == 1 && e.idx == 3'd3) begin have = 1'b1; spot[c] = 8'(-(24 + c / 2)); end
                     if (k == 2 && e.idx == 3'd5) begin have = 1'b1; spot[c] = 8'(40 + c);        end
                  end
                  if (have) begin
                     total++;
                     if (row_out !== spot) begin
                        bad++;
                        $display("FAIL modes_spot case=%0d row=%0d got=%h want=%h", k, e.idx, row_out, spot);
                     end
                  end
               end
            end
            @(negedge clk);
         end
         total++;
         if (rows !== 8 || sbq.size() !== 0) begin
            bad++;
            $display("FAIL modes_count case=%0d got rows=%0d left=%0d want rows=8 left=0", k, rows, sbq.size());
         end
         sbq.delete();
      end
   endtask

   task automatic test_backpressure();
      blk_t blk;
      exp_t e;
      logic exp_rdy;
      logic held;
      logic [70:0] prev;
      int   rows;
      blk = make_blk(3);
      @(negedge clk);
      valid_in = 1'b1; ch_in = 2'd1; mode_in = 2'b01; block_in = blk; ready_out = 1'b1;
      #1;
      total++;
      if (ready_in !== 1'b1) begin
         bad++;
         $display("FAIL bp_accept got ready_in=%0b want=1", ready_in);
      end
      push_block(blk, 2'd1, 2'b01);
      @(negedge clk);
      valid_in = 1'b0;
      held = 1'b0;
      prev = '0;
      rows = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         ready_out = (cyc % 4 == 0) || (cyc % 4 == 3);
         #1;
         exp_rdy = (sbq.size() == 0) || (sbq.size() == 1 && ready_out);
         total++;
         if (ready_in !== exp_rdy) begin
            bad++;
            $display("FAIL bp_ready_in cyc=%0d got=%0b want=%0b", cyc, ready_in, exp_rdy);
         end
         if (held) begin
            total++;
            if ({valid_out, row_out, row_idx_out, ch_out, last_out} !== prev) begin
               bad++;
               $display("FAIL bp_stable cyc=%0d got=%h want=%h", cyc,
                        {valid_out, row_out, row_idx_out, ch_out, last_out}, prev);
            end
         end
         held = valid_out && !ready_out;
         prev = {valid_out, row_out, row_idx_out, ch_out, last_out};
         if (valid_out && ready_out) begin
            rows++;
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL bp_extra_row cyc=%0d got idx=%0d want no row", cyc, row_idx_out);
            end else begin
               e = sbq.pop_front();
               total++;
               if ({row_out, row_idx_out, ch_out, last_out} !== {e.row, e.idx, e.ch, e.last}) begin
                  bad++;
                  $display("FAIL bp_row got row=%h idx=%0d ch=%0d last=%0b want row=%h idx=%0d ch=%0d last=%0b",
                           row_out, row_idx_out, ch_out, last_out, e.row, e.idx, e.ch, e.last);
               end
            end
         end
         @(negedge clk);
      end
      total++;
      if (rows !== 8 || sbq.size() !== 0) begin
         bad++;
         $display("FAIL bp_count got rows=%0d left=%0d want rows=8 left=0", rows, sbq.size());
      end
      sbq.delete();
      ready_out = 1'b1;
   endtask

   task automatic test_back_to_back();
      blk_t blk_a;
      blk_t blk_b;
      exp_t e;
      logic exp_rdy;
      int   pulses;
      blk_a = make_blk(0);
      blk_b = make_blk(3);
      @(negedge clk);
      valid_in = 1'b1; ch_in = 2'd1; mode_in = 2'b10; block_in = blk_a; ready_out = 1'b1;
      #1;
      total++;
      if (ready_in !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first_accept got ready_in=%0b want=1", ready_in);
      end
      push_block(blk_a, 2'd1, 2'b10);
      @(negedge clk);
      block_in = blk_b;
      pulses = 0;
      for (int cyc = 1; cyc <= 18; cyc++) begin
         if (pulses > 0) valid_in = 1'b0;
         #1;
         total++;
         if (valid_out !== (cyc <= 16)) begin
            bad++;
            $display("FAIL b2b_valid cyc=%0d got=%0b want=%0b", cyc, valid_out, cyc <= 16);
         end
         exp_rdy = (sbq.size() <= 1);
         total++;
         if (ready_in !== exp_rdy) begin
            bad++;
            $display("FAIL b2b_ready_in cyc=%0d got=%0b want=%0b", cyc, ready_in, exp_rdy);
         end
         if (valid_out && ready_out) begin
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL b2b_extra_row cyc=%0d got idx=%0d want no row", cyc, row_idx_out);
            end else begin
               e = sbq.pop_front();
               total++;
               if ({row_out, row_idx_out, ch_out, last_out} !== {e.row, e.idx, e.ch, e.last}) begin
                  bad++;
                  $display("FAIL b2b_row cyc=%0d got row=%h idx=%0d ch=%0d last=%0b want row=%h idx=%0d ch=%0d last=%0b",
                           cyc, row_out, row_idx_out, ch_out, last_out, e.row, e.idx, e.ch, e.last);
               end
            end
         end
         if (valid_in && ready_in) begin
            pulses++;
            push_block(blk_b, 2'd1, 2'b10);
         end
         @(negedge clk);
      end
      total++;
      if (pulses !== 1 || sbq.size() !== 0) begin
         bad++;
         $display("FAIL b2b_pulses got pulses=%0d left=%0d want pulses=1 left=0", pulses, sbq.size());
      end
      sbq.delete();
   endtask

   task automatic test_illegal();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         valid_in = 1'b1; ready_out = 1'b1; block_in = make_blk(3);
         ch_in   = (k == 0) ? 2'd1 : 2'd3;
         mode_in = (k == 0) ? 2'b11 : 2'b00;
         #1;
         total++;
         if (ready_in !== 1'b1) begin
            bad++;
            $display("FAIL illegal_accept case=%0d got ready_in=%0b want=1", k, ready_in);
         end
         @(negedge clk);
         valid_in = 1'b0;
         for (int cyc = 1; cyc <= 4; cyc++) begin
            #1;
            total++;
            if (err_out !== (cyc == 1)) begin
               bad++;
               $display("FAIL illegal_err case=%0d cyc=%0d got=%0b want=%0b", k, cyc, err_out, cyc == 1);
            end
            total++;
            if (valid_out !== 1'b0) begin
               bad++;
               $display("FAIL illegal_valid case=%0d cyc=%0d got=%0b want=0", k, cyc, valid_out);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset_mid();
      blk_t blk;
      exp_t e;
      bit   found;
      blk = make_blk(3);
      @(negedge clk);
      valid_in = 1'b1; ch_in = 2'd2; mode_in = 2'b00; block_in = blk; ready_out = 1'b1;
      #1;
      push_block(blk, 2'd2, 2'b00);
      @(negedge clk);
      valid_in = 1'b0;
      found = 1'b0;
      for (int cyc = 0; cyc < 12 && !found; cyc++) begin
         #1;
         if (valid_out && row_idx_out == 3'd4) begin
            found = 1'b1;
         end else begin
            if (valid_out && sbq.size() != 0) begin
               e = sbq.pop_front();
               total++;
               if ({row_out, row_idx_out, ch_out, last_out} !== {e.row, e.idx, e.ch, e.last}) begin
                  bad++;
                  $display("FAIL rstmid_row got row=%h idx=%0d ch=%0d last=%0b want row=%h idx=%0d ch=%0d last=%0b",
                           row_out, row_idx_out, ch_out, last_out, e.row, e.idx, e.ch, e.last);
               end
            end
            @(negedge clk);
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL rstmid_row4 got no row 4 within 12 cycles want row 4");
      end
      rst = 1'b1;
      #1;
      total++;
      if ({valid_out, row_out, row_idx_out, ch_out, last_out, err_out} !== '0) begin
         bad++;
         $display("FAIL rstmid_clear got valid=%0b row=%h idx=%0d ch=%0d last=%0b err=%0b want all 0",
                  valid_out, row_out, row_idx_out, ch_out, last_out, err_out);
      end
      sbq.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         #1;
         total++;
         if (valid_out !== 1'b0 || row_out !== '0) begin
            bad++;
            $display("FAIL rstmid_silent cyc=%0d got valid=%0b row=%h want valid=0 row=0", cyc, valid_out, row_out);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_modes();
      test_backpressure();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chroma_upsample_stream.md
# chroma_upsample_stream

Parametrised chroma upsampler that sits between the IDCT/dequant stage and colour conversion. It accepts one subsampled block per handshake and reconstructs a full 8x8 block by sample replication in one of three modes: 4:4:4 passthrough, 4:2:2 horizontal and 4:2:0 horizontal+vertical. It streams the result out one 8-sample row per cycle under valid/ready backpressure. Luma blocks always pass through unchanged.

## Interface
- DW, 8: sample width in bits, signed.
- CH, 3: channel count; ch 0 = Y, ch 1..CH-1 = chroma.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  input block valid.
- ready_in  out  1  block accepted on valid_in && ready_in.
- ch_in  in  $clog2(CH+1)  channel id of the input block.
- mode_in  in  2  00 = 4:4:4, 01 = 4:2:2, 10 = 4:2:0, 11 = reserved.
- block_in  in  signed [DW-1:0] [7:0][7:0]  input samples, indexed [row][col]. Mode 01 uses cols 0..3; mode 10 uses rows 0..3 and cols 0..3. Unused entries are ignored.
- valid_out  out  1  row_out valid.
- ready_out  in  1  downstream accepts the row on valid_out && ready_out.
- row_out  out  signed [DW-1:0] [7:0]  current output row, indexed [col].
- row_idx_out  out  3  index of the row being presented (0..7).
- ch_out  out  $clog2(CH+1)  channel of the block being streamed.
- last_out  out  1  high with row 7 (row_idx_out == 7).
- err_out  out  1  one-cycle pulse on acceptance of an illegal block.

## Operation
- Storage: a single block buffer of 64 x DW bits, plus latched ch, effective mode and a 3-bit row counter r.
- States:
  - IDLE: no block buffered.
  - STREAM: block buffered; rows are being presented.
- Acceptance condition: ready_in = (state == IDLE) || (state == STREAM && r == 7 && ready_out). This allows back-to-back blocks with no bubble.
- On acceptance:
  - Latch block_in, ch_in and the effective mode into the buffer.
  - Set r = 0 and enter STREAM.
  - Effective mode is 00 if ch_in == 0; otherwise it is mode_in.
- Illegal block: mode_in == 11 with ch_in != 0, or ch_in >= CH.
  - The block is consumed (handshake completes) but not streamed.
  - err_out pulses for exactly one cycle in the cycle after acceptance.
  - The state goes to IDLE, unless the acceptance is the back-to-back case, in which case the state also goes to IDLE once row 7 is consumed.
- Row generation, combinational from the buffer and r (no path from block_in):
  - Mode 00: row_out[c] = buf[r][c].
  - Mode 01: row_out[c] = buf[r][c>>1].
  - Mode 10: row_out[c] = buf[r>>1][c>>1].
  - The 4:2:0 case matches the legacy 4x4 -> 8x8 mapping: in[i][j] fills out[2i..2i+1][2j..2j+1].
- Samples are copied bit-exact. There is no arithmetic and no sign change.
- In STREAM, valid_out = 1, row_idx_out = r, ch_out = latched ch, and last_out = (r == 7).
- r advances on valid_out && ready_out. When row 7 is consumed:
  - If a new legal block is accepted in the same cycle, stay in STREAM with r = 0.
  - Otherwise go to IDLE.
- When valid_out = 0, row_out, row_idx_out, ch_out and last_out are driven to 0.
- While valid_out = 1 and ready_out = 0, every output holds stable.

## Timing
- Reset: state IDLE, r = 0, buffer cleared, valid_out = 0, row_out = 0, row_idx_out = 0, ch_out = 0, last_out = 0, err_out = 0. ready_in = 1 in the first cycle after reset deassertion.
- Reset mid-stream: the buffered block is discarded and no further rows are emitted.
- Latency: a block accepted at edge k presents row 0 in cycle k+1 (after edge k).
- Throughput: with ready_out held at 1, one block per 8 cycles and no idle cycles between blocks.
- Combinational paths: the only input-to-output path is ready_out -> ready_in. All other outputs are a function of registered state only.
- err_out is registered and lasts exactly one cycle. It does not affect valid_out.

## Test plan
- Reset, then a 4:2:0 Cb block (ch 1, block_in[i][j] = 16*i + j for i,j < 4), ready_out = 1:
  - rows 0..7 appear in cycles 1..8.
  - row 0 = row 1 = {0,0,1,1,2,2,3,3}; row 6 = {48,48,49,49,50,50,51,51}.
  - last_out is high only with row 7.
- 4:2:2 Cr block (ch 2, block_in[r][c] = -(8*r + c)):
  - row 3 = {-24,-24,-25,-25,-26,-26,-27,-27}.
  - ch_out = 2 on all 8 rows.
- Y block (ch 0) with mode_in = 10 and block_in[r][c] = 8*r + c:
  - treated as passthrough; row 5 = {40..47}.
  - err_out stays 0.
- Backpressure: ready_out toggles 1,0,0,1,...:
  - each row is held stable while stalled; rows are never skipped or repeated.
  - ready_in is 0 until row 7 with ready_out = 1.
- Back-to-back: two 4:2:0 blocks, with valid_in held high and ready_out = 1:
  - 16 consecutive valid rows; the second block's row 0 directly follows the first block's row 7.
  - ready_in pulses once, on the row-7 cycle.
- Illegal input and reset:
  - ch 1, mode 11 -> handshake completes, err_out = 1 for exactly one cycle, valid_out stays 0.
  - rst asserted during row 4 -> all outputs go to 0 immediately, and no rows are emitted after reset deasserts.
